btn_debounce: RTL

Multi-channel pushbutton conditioner for the Pong board inputs (paddle up/down, serve, pause). Each raw, asynchronous button line is double-flop synchronized, debounced by a per-channel counter state machine, and presented to game logic as a clean level plus single-cycle press/release pulses. It complements the reset synchronizer: that block cleans the asynchronous reset, and this block cleans every other asynchronous input before it reaches the game FSMs.

---
 rtl/pong_pkg.sv | 15 +
 rtl/debounce_cell.sv | 146 ++++++++++++++
 rtl/btn_debounce.sv | 43 ++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong board definitions: button FSM state encoding and default timing constants.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_HI = 2'b01,
    HELD    = 2'b11,
    WAIT_LO = 2'b10
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchronizer, debounce FSM with counter, registered level/pulses.
// Optional auto-repeat of btn_press while held, enabled by defining BTN_AUTOREPEAT_EN.
module debounce_cell
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       syncS1_q, syncS2_q;
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter is sized from the repeat constants so it never limits the debounce width.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
  logic             rptPeriodic_q, rptPeriodic_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncS1_q  <= 1'b0;
      syncS2_q  <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      syncS1_q  <= btn_i;
      syncS2_q  <= syncS1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptCnt_q      <= '0;
      rptPeriodic_q <= 1'b0;
    end else begin
      rptCnt_q      <= rptCnt_d;
      rptPeriodic_q <= rptPeriodic_d;
    end
  end
`endif

  // The repeat counter only survives consecutive HELD cycles; any other state clears it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rptCnt_d      = '0;
    rptPeriodic_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (syncS2_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!syncS2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!syncS2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rptCnt_q == (rptPeriodic_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
          press_d       = 1'b1;
          rptCnt_d      = '0;
          rptPeriodic_d = 1'b1;
        end else begin
          rptCnt_d      = rptCnt_q + 1'b1;
          rptPeriodic_d = rptPeriodic_q;
        end
`endif
      end
      WAIT_LO: begin
        if (syncS2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton conditioner: WIDTH independent debounce_cell channels.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses while a button is held.
module btn_debounce
  import pong_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

`ifndef BTN_AUTOREPEAT_EN
  localparam int unusedRepeatCfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : gen_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_in[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

endmodule
